// File: rtl/weights_channel_sequencer_if.sv
// Handshake bundle between the layer controller, the weights loader, the systolic array
// and the channel sequencer. The sequencer takes the slave view.
interface weights_channel_sequencer_if #(
  parameter int CH_W = 7
);
  logic            i_start;
  logic            i_abort;
  logic [CH_W-1:0] i_num_ch;
  logic [CH_W-1:0] o_current_ch;
  logic            o_weights_start;
  logic            i_weights_ended;
  logic            o_sa_weights_valid;
  logic            i_sa_done;
  logic            o_busy;
  logic            o_done;
  logic            o_timeout_err;

  modport slave (
    input  i_start, i_abort, i_num_ch, i_weights_ended, i_sa_done,
    output o_current_ch, o_weights_start, o_sa_weights_valid, o_busy, o_done, o_timeout_err
  );

  modport master (
    output i_start, i_abort, i_num_ch, i_weights_ended, i_sa_done,
    input  o_current_ch, o_weights_start, o_sa_weights_valid, o_busy, o_done, o_timeout_err
  );
endinterface

// File: rtl/weights_channel_sequencer.sv
// Walks one convolution layer channel by channel: request a weight load, wait for it
// (with a watchdog), let the systolic array compute, then advance to the next channel.
module weights_channel_sequencer #(
  parameter int CH_W      = 7,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  weights_channel_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_END,
    COMPUTE,
    NEXT,
    DONE,
    ERR
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  logic [CH_W-1:0]      num_ch;
  logic [TIMEOUT_W-1:0] watchdog;

  // Every output is registered alongside the state it belongs to; abort overrides all events.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state                  <= IDLE;
      num_ch                 <= '0;
      watchdog               <= '0;
      bus.o_current_ch       <= '0;
      bus.o_weights_start    <= 1'b0;
      bus.o_sa_weights_valid <= 1'b0;
      bus.o_busy             <= 1'b0;
      bus.o_done             <= 1'b0;
      bus.o_timeout_err      <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      if (bus.i_abort) begin
        state                  <= IDLE;
        bus.o_current_ch       <= '0;
        bus.o_weights_start    <= 1'b0;
        bus.o_sa_weights_valid <= 1'b0;
        bus.o_busy             <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (bus.i_start) begin
              num_ch            <= bus.i_num_ch;
              bus.o_timeout_err <= 1'b0;
              if (bus.i_num_ch == '0) begin
                state      <= DONE;
                bus.o_done <= 1'b1;
              end else begin
                state               <= LOAD;
                bus.o_current_ch    <= CH_W'(1);
                bus.o_weights_start <= 1'b1;
                bus.o_busy          <= 1'b1;
              end
            end
          end

          LOAD: begin
            state    <= WAIT_END;
            watchdog <= '0;
          end

          // A completion arriving on the expiry cycle still counts as a successful load.
          WAIT_END: begin
            if (bus.i_weights_ended) begin
              state                  <= COMPUTE;
              bus.o_weights_start    <= 1'b0;
              bus.o_sa_weights_valid <= 1'b1;
            end else if (watchdog == WD_LAST) begin
              state               <= ERR;
              bus.o_timeout_err   <= 1'b1;
              bus.o_weights_start <= 1'b0;
              bus.o_current_ch    <= '0;
              bus.o_busy          <= 1'b0;
            end else if (watchdog != '1) begin
              watchdog <= watchdog + TIMEOUT_W'(1);
            end
          end

          COMPUTE: begin
            if (bus.i_sa_done) begin
              state                  <= NEXT;
              bus.o_sa_weights_valid <= 1'b0;
            end
          end

          // Compare before incrementing so a full-range channel count never wraps to 0.
          NEXT: begin
            if (bus.o_current_ch == num_ch) begin
              state            <= DONE;
              bus.o_current_ch <= '0;
              bus.o_busy       <= 1'b0;
              bus.o_done       <= 1'b1;
            end else begin
              state               <= LOAD;
              bus.o_current_ch    <= bus.o_current_ch + CH_W'(1);
              bus.o_weights_start <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weights_channel_sequencer.sv
// Directed bench for the channel sequencer: full layers, empty layer, watchdog, abort,
// ignored restarts, asynchronous reset and the full-range channel count.
module tb_weights_channel_sequencer;

  localparam int CH_W      = 7;
  localparam int TIMEOUT_W = 16;
  localparam int TIMEOUT   = 16;

  logic clk;
  logic rstn;
  int   n_asserts   = 0;
  int   n_failures  = 0;
  int   load_pulses = 0;
  int   done_pulses = 0;

  weights_channel_sequencer_if #(.CH_W(CH_W)) bus ();

  weights_channel_sequencer #(
    .CH_W      (CH_W),
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus.o_weights_start) load_pulses++;
  always @(posedge bus.o_done) done_pulses++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, "_start"}, 32'(bus.o_weights_start), 32'd0);
    check_output({tag, "_valid"}, 32'(bus.o_sa_weights_valid), 32'd0);
    check_output({tag, "_ch"}, 32'(bus.o_current_ch), 32'd0);
    check_output({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic apply_stimulus(input int num_ch);
    bus.i_start  = 1'b1;
    bus.i_num_ch = CH_W'(num_ch);
    tick();
    bus.i_start  = 1'b0;
  endtask

  // Entered just after the edge that put the sequencer in LOAD for channel ch.
  task automatic do_channel(input int ch, input int ended_delay, input int done_delay,
                            input bit last, input bit poke);
    for (int i = 1; i < ended_delay; i++) begin
      if (poke && i == 2) begin
        bus.i_start  = 1'b1;
        bus.i_num_ch = CH_W'(5);
      end
      tick();
      bus.i_start = 1'b0;
    end
    check_output("load_req", 32'(bus.o_weights_start), 32'd1);
    check_output("load_ch", 32'(bus.o_current_ch), 32'(ch));
    bus.i_weights_ended = 1'b1;
    tick();
    bus.i_weights_ended = 1'b0;
    check_output("valid_on", 32'(bus.o_sa_weights_valid), 32'd1);
    check_output("req_off", 32'(bus.o_weights_start), 32'd0);
    check_output("compute_ch", 32'(bus.o_current_ch), 32'(ch));
    for (int i = 1; i < done_delay; i++) begin
      if (poke && i == 1) bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
    end
    check_output("valid_hold", 32'(bus.o_sa_weights_valid), 32'd1);
    bus.i_sa_done = 1'b1;
    tick();
    bus.i_sa_done = 1'b0;
    check_output("next_valid", 32'(bus.o_sa_weights_valid), 32'd0);
    check_output("next_gap", 32'(bus.o_weights_start), 32'd0);
    check_output("next_busy", 32'(bus.o_busy), 32'd1);
    tick();
    if (last) begin
      check_output("last_done", 32'(bus.o_done), 32'd1);
      check_output("last_ch", 32'(bus.o_current_ch), 32'd0);
      check_output("last_busy", 32'(bus.o_busy), 32'd0);
    end else begin
      check_output("adv_req", 32'(bus.o_weights_start), 32'd1);
      check_output("adv_ch", 32'(bus.o_current_ch), 32'(ch + 1));
      check_output("adv_busy", 32'(bus.o_busy), 32'd1);
    end
  endtask

  initial begin
    rstn                = 1'b1;
    bus.i_start         = 1'b0;
    bus.i_abort         = 1'b0;
    bus.i_num_ch        = '0;
    bus.i_weights_ended = 1'b0;
    bus.i_sa_done       = 1'b0;

    $display("[TB] reset state");
    #2 rstn = 1'b0;
    #1;
    check_quiet("rst");
    check_output("rst_done", 32'(bus.o_done), 32'd0);
    check_output("rst_err", 32'(bus.o_timeout_err), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] three-channel layer");
    load_pulses = 0;
    done_pulses = 0;
    apply_stimulus(3);
    check_output("t1_first_req", 32'(bus.o_weights_start), 32'd1);
    check_output("t1_first_ch", 32'(bus.o_current_ch), 32'd1);
    for (int ch = 1; ch <= 3; ch++) do_channel(ch, 5, 10, ch == 3, 1'b0);
    tick();
    check_output("t1_done_once", 32'(bus.o_done), 32'd0);
    check_output("t1_load_pulses", 32'(load_pulses), 32'd3);
    check_output("t1_done_pulses", 32'(done_pulses), 32'd1);
    check_quiet("t1_end");

    $display("[TB] empty layer");
    load_pulses = 0;
    apply_stimulus(0);
    check_output("t2_done", 32'(bus.o_done), 32'd1);
    check_quiet("t2");
    tick();
    check_output("t2_done_drop", 32'(bus.o_done), 32'd0);
    check_output("t2_no_load", 32'(load_pulses), 32'd0);

    $display("[TB] load watchdog");
    apply_stimulus(2);
    for (int i = 0; i < TIMEOUT; i++) tick();
    check_output("t3_still_wait", 32'(bus.o_weights_start), 32'd1);
    check_output("t3_no_err_yet", 32'(bus.o_timeout_err), 32'd0);
    tick();
    check_output("t3_err", 32'(bus.o_timeout_err), 32'd1);
    check_quiet("t3_err");
    tick();
    check_output("t3_err_sticky", 32'(bus.o_timeout_err), 32'd1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check_output("t3_abort_keeps_err", 32'(bus.o_timeout_err), 32'd1);
    check_quiet("t3_abort");
    apply_stimulus(2);
    check_output("t3_err_clear", 32'(bus.o_timeout_err), 32'd0);
    check_output("t3_restart_ch", 32'(bus.o_current_ch), 32'd1);

    $display("[TB] abort during compute");
    do_channel(1, 2, 2, 1'b0, 1'b0);
    tick();
    bus.i_weights_ended = 1'b1;
    tick();
    bus.i_weights_ended = 1'b0;
    check_output("t4_compute_ch2", 32'(bus.o_sa_weights_valid), 32'd1);
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    check_quiet("t4_abort");
    check_output("t4_abort_done", 32'(bus.o_done), 32'd0);
    tick();
    check_quiet("t4_idle");

    $display("[TB] restarts while busy are ignored");
    done_pulses = 0;
    apply_stimulus(2);
    check_output("t5_first_ch", 32'(bus.o_current_ch), 32'd1);
    do_channel(1, 4, 3, 1'b0, 1'b1);
    do_channel(2, 4, 3, 1'b1, 1'b1);
    check_output("t5_done_pulses", 32'(done_pulses), 32'd1);

    $display("[TB] asynchronous reset mid-load");
    apply_stimulus(2);
    tick();
    tick();
    check_output("t6_waiting", 32'(bus.o_weights_start), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_quiet("t6_async");
    tick();
    rstn = 1'b1;
    bus.i_weights_ended = 1'b1;
    tick();
    bus.i_weights_ended = 1'b0;
    check_quiet("t6_ignored");
    tick();
    check_output("t6_valid_idle", 32'(bus.o_sa_weights_valid), 32'd0);

    $display("[TB] full-range channel count");
    done_pulses = 0;
    apply_stimulus(127);
    for (int ch = 1; ch <= 127; ch++) do_channel(ch, 2, 1, ch == 127, 1'b0);
    tick();
    check_output("t7_done_pulses", 32'(done_pulses), 32'd1);
    check_quiet("t7_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
